// File: rtl/mor1kx_rf_multiport.sv
// rtl/mor1kx_rf_multiport.sv - multi-port GPR file with bypass network, shadow sets and optional clear sweep
// Optional post-reset clear sweep built when MOR1KX_RF_CLEAR_SWEEP_EN is defined.
module mor1kx_rf_multiport #(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    parameter int NUM_READ_PORTS           = 2,
    parameter int NUM_BYPASS_STAGES        = 3,
    localparam int W     = OPTION_OPERAND_WIDTH,
    localparam int A     = OPTION_RF_ADDR_WIDTH,
    localparam int R     = NUM_READ_PORTS,
    localparam int S     = NUM_BYPASS_STAGES,
    localparam int C     = 1 + OPTION_RF_NUM_SHADOW_GPR,
    localparam int CW    = (C > 1) ? $clog2(C) : 1,
    localparam int DEPTH = C * (2 ** A),
    localparam int PAW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    ctx_i,
    input  logic             rd_adr_valid_i,
    input  logic [R*A-1:0]   rd_adr_i,
    output logic [R*W-1:0]   rd_dat_o,
    input  logic [S-1:0]     byp_valid_i,
    input  logic [S*A-1:0]   byp_adr_i,
    input  logic [S*W-1:0]   byp_dat_i,
    input  logic             wb_we_i,
    input  logic [A-1:0]     wb_adr_i,
    input  logic [W-1:0]     wb_dat_i,
    output logic             busy_o
);

    logic [W-1:0]          mem [DEPTH];
    logic                  busy;
    logic                  capture;
    logic                  wb_acc;
    logic                  ram_we;
    logic [PAW-1:0]        ram_wadr;
    logic [W-1:0]          ram_wdat;
    logic [R-1:0][A-1:0]   adr_q;
    logic [R-1:0]          hold_q;
    logic [R-1:0][W-1:0]   hold_dat_q;
    logic [R-1:0][W-1:0]   ram_q;
    logic [W-1:0]          port_val;

    // Physical address {ctx, index}; with a single set the context bit falls away.
    function automatic logic [PAW-1:0] phys(input logic [CW-1:0] ctx, input logic [A-1:0] idx);
        logic [CW+A-1:0] full;
        full = {ctx, idx};
        return full[PAW-1:0];
    endfunction

    assign capture = rd_adr_valid_i && !busy;
    assign wb_acc  = wb_we_i && !busy;
    assign busy_o  = busy;

`ifdef MOR1KX_RF_CLEAR_SWEEP_EN
    typedef enum logic {CLEAR, READY} sweep_state_t;

    sweep_state_t   state;
    logic [PAW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == PAW'(DEPTH - 1))
                state <= READY;
            else
                cnt <= cnt + PAW'(1);
        end
    end

    assign busy     = (state == CLEAR);
    assign ram_we   = busy || wb_acc;
    assign ram_wadr = busy ? cnt : phys(ctx_i, wb_adr_i);
    assign ram_wdat = busy ? '0 : wb_dat_i;
`else
    assign busy     = 1'b0;
    assign ram_we   = wb_we_i;
    assign ram_wadr = phys(ctx_i, wb_adr_i);
    assign ram_wdat = wb_dat_i;
`endif

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_wadr] <= ram_wdat;
    end

    // The RAM returns pre-write data; the hold path covers writes that land after the read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q      <= '0;
            hold_q     <= '0;
            hold_dat_q <= '0;
            ram_q      <= '0;
        end else begin
            for (int p = 0; p < R; p++) begin
                if (capture) begin
                    adr_q[p] <= rd_adr_i[p*A +: A];
                    ram_q[p] <= mem[phys(ctx_i, rd_adr_i[p*A +: A])];
                    if (wb_acc && wb_adr_i == rd_adr_i[p*A +: A]) begin
                        hold_q[p]     <= 1'b1;
                        hold_dat_q[p] <= wb_dat_i;
                    end else begin
                        hold_q[p] <= 1'b0;
                    end
                end else if (wb_acc && wb_adr_i == adr_q[p]) begin
                    hold_q[p]     <= 1'b1;
                    hold_dat_q[p] <= wb_dat_i;
                end
            end
        end
    end

    // Youngest stage is scanned last so it overrides older matches.
    always_comb begin
        rd_dat_o = '0;
        port_val = '0;
        for (int p = 0; p < R; p++) begin
            port_val = hold_q[p] ? hold_dat_q[p] : ram_q[p];
            for (int s = S - 1; s >= 0; s--) begin
                if (byp_valid_i[s] && byp_adr_i[s*A +: A] == adr_q[p])
                    port_val = byp_dat_i[s*W +: W];
            end
            rd_dat_o[p*W +: W] = busy ? '0 : port_val;
        end
    end

endmodule

// File: tb/tb_mor1kx_rf_multiport.sv
// tb/tb_mor1kx_rf_multiport.sv - randomized and directed check of mor1kx_rf_multiport against a register-level model
module tb_mor1kx_rf_multiport;
    localparam int W = 32, A = 5, R = 2, S = 3, NSETS = 2, NREG = 32, DEPTH = 64;
`ifdef MOR1KX_RF_CLEAR_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ctx;
    logic           rd_adr_valid;
    logic [R*A-1:0] rd_adr;
    logic [R*W-1:0] rd_dat;
    logic [S-1:0]   byp_valid;
    logic [S*A-1:0] byp_adr;
    logic [S*W-1:0] byp_dat;
    logic           wb_we;
    logic [A-1:0]   wb_adr;
    logic [W-1:0]   wb_dat;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mor1kx_rf_multiport #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_RF_ADDR_WIDTH(A),
        .OPTION_RF_NUM_SHADOW_GPR(1),
        .NUM_READ_PORTS(R),
        .NUM_BYPASS_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctx_i(ctx),
        .rd_adr_valid_i(rd_adr_valid),
        .rd_adr_i(rd_adr),
        .rd_dat_o(rd_dat),
        .byp_valid_i(byp_valid),
        .byp_adr_i(byp_adr),
        .byp_dat_i(byp_dat),
        .wb_we_i(wb_we),
        .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat),
        .busy_o(busy)
    );

    // Architectural model: register contents per set, plus the set/indices last captured.
    logic [W-1:0] m_mem [NSETS][NREG];
    logic         m_ctx;
    logic [A-1:0] m_adr [R];
    bit           m_valid;
    int           m_bcnt;

    function automatic bit m_busy();
        return SWEEP && (m_bcnt < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bcnt  <= 0;
            m_valid <= 1'b0;
            if (SWEEP)
                for (int c = 0; c < NSETS; c++)
                    for (int i = 0; i < NREG; i++)
                        m_mem[c][i] <= '0;
        end else begin
            if (!m_busy()) begin
                if (wb_we)
                    m_mem[ctx][wb_adr] <= wb_dat;
                if (rd_adr_valid) begin
                    m_ctx   <= ctx;
                    m_valid <= 1'b1;
                    for (int p = 0; p < R; p++)
                        m_adr[p] <= rd_adr[p*A +: A];
                end
            end
            if (m_bcnt < DEPTH)
                m_bcnt <= m_bcnt + 1;
        end
    end

    function automatic logic [W-1:0] m_expect(input int p);
        if (m_busy())
            return '0;
        for (int s = 0; s < S; s++)
            if (byp_valid[s] && byp_adr[s*A +: A] == m_adr[p])
                return byp_dat[s*W +: W];
        return m_mem[m_ctx][m_adr[p]];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (busy !== m_busy()) begin
                n_fail++;
                $display("FAIL busy_model t=%0t: got %b expected %b", $time, busy, m_busy());
            end
            if (m_valid || m_busy()) begin
                for (int p = 0; p < R; p++) begin
                    n_checks++;
                    if (rd_dat[p*W +: W] !== m_expect(p)) begin
                        n_fail++;
                        $display("FAIL rd_dat_model port%0d t=%0t: got %h expected %h",
                                 p, $time, rd_dat[p*W +: W], m_expect(p));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [A-1:0] rand_adr();
        if ($urandom_range(0, 3) == 0)
            return A'($urandom_range(0, NREG - 1));
        return A'($urandom_range(0, 7));
    endfunction

    int n_busy;

    initial begin
        ctx = 1'b0; rd_adr_valid = 1'b0; rd_adr = '0;
        byp_valid = '0; byp_adr = '0; byp_dat = '0;
        wb_we = 1'b0; wb_adr = '0; wb_dat = '0;

        tick(3);
        chk("reset_rd_dat_lo", rd_dat[31:0], 32'h0);
        chk("reset_rd_dat_hi", rd_dat[63:32], 32'h0);
        chk("reset_busy", {31'b0, busy}, {31'b0, SWEEP});
        rst = 1'b0;
        count_busy(n_busy);
        chk("busy_cycles", W'(n_busy), SWEEP ? W'(DEPTH) : 32'd0);

`ifdef MOR1KX_RF_CLEAR_SWEEP_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(10);
        chk("busy_mid_sweep", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        count_busy(n_busy);
        chk("busy_cycles_after_midreset", W'(n_busy), W'(DEPTH));
        rd_adr_valid = 1'b1; rd_adr = {5'd31, 5'd5};
        tick();
        rd_adr_valid = 1'b0;
        chk("sweep_r5_zero", rd_dat[31:0], 32'h0);
        chk("sweep_r31_zero", rd_dat[63:32], 32'h0);
`endif

        // Fill every register of both sets; each write also captures so the model stays in step.
        for (int c = 0; c < NSETS; c++) begin
            for (int i = 0; i < NREG; i++) begin
                ctx = c[0]; wb_we = 1'b1; wb_adr = A'(i); wb_dat = $urandom;
                rd_adr_valid = 1'b1; rd_adr = {A'(i), A'(i)};
                tick();
            end
        end
        wb_we = 1'b0; rd_adr_valid = 1'b0;

        ctx = 1'b0; wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'hDEADBEEF;
        tick();
        wb_we = 1'b0; rd_adr_valid = 1'b1; rd_adr = {5'd3, 5'd0};
        tick();
        rd_adr_valid = 1'b0;
        chk("write_then_read_r3", rd_dat[63:32], 32'hDEADBEEF);

        wb_we = 1'b1; wb_adr = 5'd7; wb_dat = 32'h1234;
        rd_adr_valid = 1'b1; rd_adr = {5'd8, 5'd7};
        tick();
        wb_we = 1'b0; rd_adr_valid = 1'b0;
        chk("same_cycle_bypass_r7", rd_dat[31:0], 32'h1234);
        tick(5);
        chk("stall_hold_r7", rd_dat[31:0], 32'h1234);

        wb_we = 1'b1; wb_adr = 5'd4; wb_dat = 32'h44;
        rd_adr_valid = 1'b1; rd_adr = {5'd10, 5'd4};
        tick();
        wb_we = 1'b0; rd_adr_valid = 1'b0;
        byp_adr = {5'd4, 5'd4, 5'd4};
        byp_dat = {32'h22, 32'h11, 32'h00};
        byp_valid = 3'b111;
        #1 chk("prio_stage0", rd_dat[31:0], 32'h00);
        byp_valid = 3'b110;
        #1 chk("prio_stage1", rd_dat[31:0], 32'h11);
        byp_valid = 3'b000;
        #1 chk("prio_hold", rd_dat[31:0], 32'h44);
        tick();

        wb_we = 1'b1; wb_adr = 5'd9; wb_dat = 32'h5;
        tick();
        wb_we = 1'b0; rd_adr_valid = 1'b1; rd_adr = {5'd11, 5'd9};
        tick();
        rd_adr_valid = 1'b0;
        chk("stall_read_r9", rd_dat[31:0], 32'h5);
        tick();
        wb_we = 1'b1; wb_adr = 5'd9; wb_dat = 32'h6;
        tick();
        wb_we = 1'b0;
        chk("stall_write_r9", rd_dat[31:0], 32'h6);
        tick(2);
        chk("stall_write_r9_held", rd_dat[31:0], 32'h6);

        wb_we = 1'b1; wb_adr = 5'd2; wb_dat = 32'hA;
        tick();
        ctx = 1'b1; wb_dat = 32'hB; rd_adr_valid = 1'b1; rd_adr = {5'd12, 5'd2};
        tick();
        wb_we = 1'b0;
        chk("shadow_ctx1_bypass", rd_dat[31:0], 32'hB);
        ctx = 1'b0;
        tick();
        chk("shadow_ctx0_r2", rd_dat[31:0], 32'hA);
        ctx = 1'b1;
        tick();
        rd_adr_valid = 1'b0;
        chk("shadow_ctx1_r2", rd_dat[31:0], 32'hB);

        // Random traffic; context only moves on capture cycles, as a flushed pipeline would.
        for (int k = 0; k < 3000; k++) begin
            rd_adr_valid = 1'($urandom_range(0, 1));
            if (rd_adr_valid && $urandom_range(0, 7) == 0)
                ctx = ~ctx;
            for (int p = 0; p < R; p++)
                rd_adr[p*A +: A] = rand_adr();
            wb_we  = 1'($urandom_range(0, 1));
            wb_adr = rand_adr();
            wb_dat = $urandom;
            for (int s = 0; s < S; s++) begin
                byp_valid[s]       = ($urandom_range(0, 3) == 0);
                byp_adr[s*A +: A]  = rand_adr();
                byp_dat[s*W +: W]  = $urandom;
            end
            tick();
        end

        rd_adr_valid = 1'b0; wb_we = 1'b0; byp_valid = '0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
